pmod_serial_rx: RTL and testbench
=================================

PMOD_SERIAL_RX -- requirements
Module: pmod_serial_rx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 434, system clock cycles per serial bit (50 MHz / 115200 baud); legal range 4..65535.
REQ-002 Parameter DATA_BITS, default 8, data bits per frame; legal range 5..8.
REQ-003 clk  input  1  system clock; all state advances on its rising edge.
REQ-004 rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-005 rx_in  input  1  serial line from Pmod pin; asynchronous to clk; idle high.
REQ-006 rx_data  output  DATA_BITS  last correctly framed byte, LSB = first bit received.
REQ-007 rx_valid  output  1  one-cycle pulse; rx_data holds a new byte.
REQ-008 rx_frame_err  output  1  one-cycle pulse; stop bit sampled low.
REQ-009 rx_busy  output  1  high whenever FSM is not IDLE.

Function
REQ-010 rx_in SHALL pass through a 2-flop synchronizer (both flops reset to 1); all decisions use the second flop (rx_s).
REQ-011 FSM states SHALL be IDLE, START, DATA, STOP, BREAK.
REQ-012 IDLE: rx_s == 0 SHALL move to START and clear the bit-timer to 0.
REQ-013 START: at timer == CLKS_PER_BIT/2 - 1 (integer division) sample rx_s; 0 -> DATA, timer cleared, bit index 0; 1 -> IDLE (glitch rejected, no output pulse).
REQ-014 DATA: at timer == CLKS_PER_BIT - 1 sample rx_s into shift register bit [index], clear timer, increment index; after DATA_BITS samples go to STOP.
REQ-015 STOP: at timer == CLKS_PER_BIT - 1 sample rx_s; 1 -> load rx_data from shift register, pulse rx_valid, go IDLE; 0 -> pulse rx_frame_err, leave rx_data unchanged, go BREAK.
REQ-016 BREAK: remain until rx_s == 1, then IDLE; no new start detected while in BREAK.
REQ-017 Timer width SHALL be ceil(log2(CLKS_PER_BIT)); timer SHALL never exceed CLKS_PER_BIT - 1.
REQ-018 rx_valid and rx_frame_err SHALL be registered, high exactly one cycle, never simultaneously high.
REQ-019 rx_valid SHALL rise (2 + CLKS_PER_BIT/2 + (DATA_BITS+1)*CLKS_PER_BIT) cycles +/-1 after the rx_in falling edge.
REQ-020 A start edge arriving in the cycle IDLE is re-entered from STOP SHALL be detected (back-to-back frames with no extra idle time).
REQ-021 rx_data SHALL hold its value until the next valid frame; no consumer handshake exists, a byte not read before the next rx_valid is overwritten.

Reset
REQ-022 rst_n low SHALL immediately force: state IDLE, timer 0, index 0, shift register 0, rx_data 0, rx_valid 0, rx_frame_err 0, rx_busy 0, synchronizer flops 1.
REQ-023 Reset asserted mid-frame SHALL abandon the frame with no pulse; after release the receiver waits for a fresh falling edge and, if the line is low at release, the next falling edge after the line returns high.

Verification (CLKS_PER_BIT = 16, DATA_BITS = 8)
REQ-024 Frame 0xA5 (start 0, bits 1,0,1,0,0,1,0,1, stop 1) -> rx_data = 0xA5, single rx_valid pulse at 2+8+144 cycles +/-1 after start edge, rx_frame_err stays 0.
REQ-025 Back-to-back 0x00 then 0xFF, no idle gap -> two rx_valid pulses 160 cycles apart, rx_data 0x00 then 0xFF.
REQ-026 rx_in low for 5 cycles then high -> START aborts to IDLE, rx_busy high <= 10 cycles, no rx_valid/rx_frame_err.
REQ-027 Frame 0x3C with stop bit held low 40 cycles -> rx_frame_err one pulse, rx_data keeps prior 0xA5, rx_busy stays high until line returns high, then next frame 0x81 received correctly.
REQ-028 rst_n pulsed low during data bit 4 of frame 0x55 -> all outputs 0 immediately, no pulse for partial frame, following frame 0x12 received as 0x12.
REQ-029 Bit period skew: frame 0x96 with each bit stretched to 17 cycles and shrunk to 15 cycles -> rx_data = 0x96 in both runs.

Source files
------------

// File: rtl/pmod_serial_rx.sv
// Purpose: UART-style serial receiver for a Pmod pin (start, DATA_BITS data LSB first, one stop bit).
// Latency: rx_valid rises 2 + CLKS_PER_BIT/2 + (DATA_BITS+1)*CLKS_PER_BIT cycles after the start edge.
// Backpressure: none; rx_data is overwritten by the next good frame whether or not it was consumed.
module pmod_serial_rx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_frame_err,
  output logic                 rx_busy
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS);

  localparam logic [TW-1:0] HALF_LAST = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] BIT_LAST  = TW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } state_t;

  state_t                 state;
  logic [TW-1:0]          timer;
  logic [IW-1:0]          idx;
  logic [DATA_BITS-1:0]   shreg;
  logic                   rx_q1;
  logic                   rx_s;
  logic [1:0]             sync_fill;
  logic                   armed;

  // Two-flop synchronizer; idle-high reset value so reset never looks like a start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_q1 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      rx_q1 <= rx_in;
      rx_s  <= rx_q1;
    end
  end

  // rx_s only reflects the real line two cycles after reset release; a start edge is
  // accepted only once the real line has been seen high, so a line held low across
  // reset release is not mistaken for a new frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_fill <= 2'b00;
      armed     <= 1'b0;
    end else begin
      sync_fill <= {sync_fill[0], 1'b1};
      if (sync_fill[1] && rx_s) begin
        armed <= 1'b1;
      end
    end
  end

  // Receive FSM: bit timing, sampling, shift register and registered output pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      timer        <= '0;
      idx          <= '0;
      shreg        <= '0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
      rx_busy      <= 1'b0;
    end else begin
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
      case (state)
        IDLE: begin
          timer <= '0;
          if (armed && !rx_s) begin
            state   <= START;
            rx_busy <= 1'b1;
          end
        end
        START: begin
          if (timer == HALF_LAST) begin
            timer <= '0;
            if (!rx_s) begin
              state <= DATA;
              idx   <= '0;
            end else begin
              // Line went back high before mid start bit: treat as a glitch.
              state   <= IDLE;
              rx_busy <= 1'b0;
            end
          end else begin
            timer <= timer + TW'(1);
          end
        end
        DATA: begin
          if (timer == BIT_LAST) begin
            timer      <= '0;
            shreg[idx] <= rx_s;
            if (idx == IDX_LAST) begin
              state <= STOP;
              idx   <= '0;
            end else begin
              idx <= idx + IW'(1);
            end
          end else begin
            timer <= timer + TW'(1);
          end
        end
        STOP: begin
          if (timer == BIT_LAST) begin
            timer <= '0;
            if (rx_s) begin
              rx_data  <= shreg;
              rx_valid <= 1'b1;
              state    <= IDLE;
              rx_busy  <= 1'b0;
            end else begin
              rx_frame_err <= 1'b1;
              state        <= BREAK;
            end
          end else begin
            timer <= timer + TW'(1);
          end
        end
        BREAK: begin
          // Hold off start detection until the line is released.
          timer <= '0;
          if (rx_s) begin
            state   <= IDLE;
            rx_busy <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          timer   <= '0;
          idx     <= '0;
          rx_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pmod_serial_rx.sv
// Purpose: directed bench for pmod_serial_rx at 16 clocks per bit, 8 data bits.
// Latency: stimulus is time-driven; every wait is a fixed cycle count.
// Backpressure: none; pulses are collected by a negedge monitor.
module tb_pmod_serial_rx;

  localparam int CPB = 16;
  localparam int DB  = 8;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_in = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_frame_err;
  logic       rx_busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int nvalid = 0;
  int nerr = 0;
  int overlap = 0;
  int wide = 0;
  int busy_cnt = 0;
  int last_valid_cyc = 0;
  int prev_valid_cyc = 0;
  logic [7:0] vq[$];
  logic prev_v = 1'b0;
  logic prev_e = 1'b0;

  pmod_serial_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rx_in        (rx_in),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_frame_err (rx_frame_err),
    .rx_busy      (rx_busy)
  );

  always #5 clk = ~clk;

  // Cycle number of the most recent rising edge.
  always @(posedge clk) cyc = cyc + 1;

  // Pulse collector, sampled mid-cycle.
  always @(negedge clk) begin
    if (rx_valid) begin
      nvalid         = nvalid + 1;
      prev_valid_cyc = last_valid_cyc;
      last_valid_cyc = cyc;
      vq.push_back(rx_data);
    end
    if (rx_frame_err) nerr = nerr + 1;
    if (rx_valid && rx_frame_err) overlap = overlap + 1;
    if ((rx_valid && prev_v) || (rx_frame_err && prev_e)) wide = wide + 1;
    if (rx_busy) busy_cnt = busy_cnt + 1;
    prev_v = rx_valid;
    prev_e = rx_frame_err;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive the line for n cycles; returns 1 time unit after a rising edge.
  task automatic line(input logic v, input int n);
    rx_in = v;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Start bit is nominal; data and stop bits use dlen/slen cycles.
  task automatic send_frame(input logic [7:0] b, input int dlen, input int slen, output int t0);
    t0 = cyc;
    line(1'b0, CPB);
    for (int i = 0; i < DB; i++) line(b[i], dlen);
    line(1'b1, slen);
  endtask

  initial begin
    int t0;
    int t1;
    int n0;
    int e0;
    logic [7:0] b;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_data", rx_data, 8'h00);
    check("rst_valid", rx_valid, 1'b0);
    check("rst_err", rx_frame_err, 1'b0);
    check("rst_busy", rx_busy, 1'b0);
    rst_n = 1'b1;
    line(1'b1, 10);

    // Single frame 0xA5, latency 154 +/-1
    n0 = nvalid; e0 = nerr;
    send_frame(8'hA5, CPB, CPB, t0);
    line(1'b1, 4);
    check("a5_data", rx_data, 8'hA5);
    check("a5_nvalid", nvalid - n0, 1);
    check("a5_nerr", nerr - e0, 0);
    check("a5_latency", (last_valid_cyc - t0 >= 153) && (last_valid_cyc - t0 <= 155), 1'b1);
    check("a5_idle_busy", rx_busy, 1'b0);

    // 0x3C with stop held low 40 cycles, then 0x81
    n0 = nvalid; e0 = nerr;
    b = 8'h3C;
    line(1'b0, CPB);
    for (int i = 0; i < DB; i++) line(b[i], CPB);
    line(1'b0, 40);
    check("brk_nerr", nerr - e0, 1);
    check("brk_nvalid", nvalid - n0, 0);
    check("brk_data_kept", rx_data, 8'hA5);
    check("brk_busy_low_line", rx_busy, 1'b1);
    line(1'b1, 10);
    check("brk_busy_released", rx_busy, 1'b0);
    send_frame(8'h81, CPB, CPB, t0);
    line(1'b1, 4);
    check("after_brk_data", rx_data, 8'h81);
    check("after_brk_nvalid", nvalid - n0, 1);

    // Back-to-back 0x00 then 0xFF with no idle gap
    n0 = nvalid;
    send_frame(8'h00, CPB, CPB, t0);
    send_frame(8'hFF, CPB, CPB, t1);
    line(1'b1, 4);
    check("b2b_nvalid", nvalid - n0, 2);
    check("b2b_first", (vq.size() >= n0 + 2) ? vq[n0] : 8'hxx, 8'h00);
    check("b2b_second", (vq.size() >= n0 + 2) ? vq[n0+1] : 8'hxx, 8'hFF);
    check("b2b_spacing", last_valid_cyc - prev_valid_cyc, 160);

    // 5-cycle glitch
    n0 = nvalid; e0 = nerr;
    busy_cnt = 0;
    line(1'b0, 5);
    line(1'b1, 30);
    check("glitch_busy_window", (busy_cnt > 0) && (busy_cnt <= 10), 1'b1);
    check("glitch_nvalid", nvalid - n0, 0);
    check("glitch_nerr", nerr - e0, 0);

    // Reset in the middle of data bit 4 of 0x55
    n0 = nvalid; e0 = nerr;
    b = 8'h55;
    line(1'b0, CPB);
    for (int i = 0; i < 4; i++) line(b[i], CPB);
    line(b[4], 8);
    check("mid_busy_before_rst", rx_busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_data", rx_data, 8'h00);
    check("mid_rst_busy", rx_busy, 1'b0);
    check("mid_rst_valid", rx_valid, 1'b0);
    check("mid_rst_err", rx_frame_err, 1'b0);
    line(1'b1, 3);
    rst_n = 1'b1;
    line(1'b1, 200);
    check("mid_rst_nvalid", nvalid - n0, 0);
    check("mid_rst_nerr", nerr - e0, 0);

    // Reset released while the line is low: no frame until line goes high then low
    rx_in = 1'b0;
    rst_n = 1'b0;
    line(1'b0, 3);
    rst_n = 1'b1;
    busy_cnt = 0;
    line(1'b0, 50);
    check("low_rel_busy", busy_cnt, 0);
    line(1'b1, 20);
    check("low_rel_nvalid", nvalid - n0, 0);
    check("low_rel_nerr", nerr - e0, 0);

    send_frame(8'h12, CPB, CPB, t0);
    line(1'b1, 4);
    check("post_rst_data", rx_data, 8'h12);
    check("post_rst_nvalid", nvalid - n0, 1);

    // Bit-period skew: 17-cycle and 15-cycle bits after the start bit
    n0 = nvalid; e0 = nerr;
    send_frame(8'h96, 17, 17, t0);
    line(1'b1, 20);
    check("skew17_data", rx_data, 8'h96);
    check("skew17_nvalid", nvalid - n0, 1);
    rst_n = 1'b0;
    line(1'b1, 2);
    rst_n = 1'b1;
    line(1'b1, 10);
    check("skew_rst_data", rx_data, 8'h00);
    send_frame(8'h96, 15, 15, t0);
    line(1'b1, 20);
    check("skew15_data", rx_data, 8'h96);
    check("skew15_nvalid", nvalid - n0, 2);
    check("skew_nerr", nerr - e0, 0);

    // Pulse shape over the whole run
    check("pulse_overlap", overlap, 0);
    check("pulse_width", wide, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
